// File: rtl/mem_dpi_pkg.sv
// Shared types and memory-model access for the latency-modelled data-memory port.
// An in-language word store provides the memory model behind the helper functions.
package mem_dpi_pkg;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam int unsigned RDATA_MAX_W = 64;
    localparam int unsigned CNT_MAX_W   = 8;

    typedef struct packed {
        logic [RDATA_MAX_W-1:0] rdata;
        logic                   wr;
        logic [CNT_MAX_W-1:0]   cnt;
    } rsp_entry_t;

    function automatic logic [31:0] expand_wmask(input logic [3:0] mask);
        logic [31:0] bits;
        bits = '0;
        for (int b = 0; b < 4; b++) begin
            bits[8*b +: 8] = {8{mask[b]}};
        end
        return bits;
    endfunction

    int unsigned mem_model [int unsigned];

    function automatic int unsigned ram_read_helper(input int unsigned addr);
        if (mem_model.exists(addr)) begin
            return mem_model[addr];
        end
        return 0;
    endfunction

    function automatic void ram_write_helper(input int unsigned addr,
                                             input int unsigned wdata,
                                             input int unsigned wmask);
        int unsigned old;
        old = ram_read_helper(addr);
        mem_model[addr] = (old & ~wmask) | (wdata & wmask);
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order response queue: each slot counts down to zero; the head is ready once its count is zero.
module mem_rsp_fifo
    import mem_dpi_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  rsp_entry_t         push_entry,
    input  logic               pop,
    output logic [COUNT_W-1:0] count,
    output rsp_entry_t         head_entry,
    output logic               head_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t         entry_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [COUNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= ptr_inc(tail_q);
            if (pop)  head_q <= ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: ;
            endcase
        end
    end

    // Free slots also count down; a push overwrites the slot, so their value never matters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].cnt != '0) entry_q[i].cnt <= entry_q[i].cnt - CNT_MAX_W'(1);
        end
        if (push) entry_q[tail_q] <= push_entry;
    end

    assign count      = count_q;
    assign head_entry = entry_q[head_q];
    assign head_ready = (count_q != '0) && (head_entry.cnt == '0);

endmodule

// File: rtl/mem_dpi_lat.sv
// Request/response data-memory port over the DPI memory model with programmable response latency.
// MEM_RAND_DELAY_EN adds an LFSR-driven 0..7 cycle extra delay per accepted request.
module mem_dpi_lat
    import mem_dpi_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic                req_wen,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_wr
);

    localparam int unsigned WORDS   = DATA_W / 32;
    localparam int unsigned CNT_W   = $clog2(LATENCY + 8);
    localparam int unsigned COUNT_W = $clog2(OUTSTANDING) + 1;

    logic               accept;
    logic               pop;
    logic               head_ready;
    logic [COUNT_W-1:0] count;
    logic [CNT_W-1:0]   acc_cnt;
    rsp_entry_t         push_entry;
    rsp_entry_t         head_entry;
    logic               unused_head;

    // A same-cycle pop never frees the slot, keeping rsp_ready off the req_ready path.
    assign req_ready = !rst && (count < COUNT_W'(OUTSTANDING));
    assign accept    = req_valid && req_ready;
    assign pop       = head_ready && rsp_ready;

    assign rsp_valid   = head_ready;
    assign rsp_rdata   = head_ready ? head_entry.rdata[DATA_W-1:0] : '0;
    assign rsp_wr      = head_ready && head_entry.wr;
    assign unused_head = ^{head_entry.rdata, head_entry.cnt};

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign acc_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[2:0]);
`else
    assign acc_cnt = CNT_W'(LATENCY - 1);
`endif

    // The read samples memory before this edge's write lands, giving read-before-write data.
    always_comb begin
        push_entry     = '0;
        push_entry.wr  = req_wen;
        push_entry.cnt = CNT_MAX_W'(acc_cnt);
        if (accept) begin
            for (int i = 0; i < WORDS; i++) begin
                push_entry.rdata[32*i +: 32] = ram_read_helper(req_addr + 32'(4 * i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_wen) begin
            for (int i = 0; i < WORDS; i++) begin
                ram_write_helper(req_addr + 32'(4 * i), req_wdata[32*i +: 32],
                                 expand_wmask(req_wmask[4*i +: 4]));
            end
        end
    end

    mem_rsp_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_entry(push_entry),
        .pop       (pop),
        .count     (count),
        .head_entry(head_entry),
        .head_ready(head_ready)
    );

endmodule
